// File: rtl/sbil_pkg.sv
// Shared constants and helpers for the bilinear shift-weight pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sbil_pkg;

  // Bit positions inside the 2-bit mode field.
  localparam int MODE_RND = 0;
  localparam int MODE_SAT = 1;

  // Four terms of DATA_W bits need two extra bits; one spare keeps the sum
  // signed-safe even if a term ever uses its full DATA_W+1 range.
  function automatic int sum_w(input int data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/sbil_lane.sv
// One channel of datapath: per-corner shift/round terms, then sum and narrow.
// Latency: purely combinational; the parent registers between the halves.
// Backpressure: none here, handshake lives in the parent.
module sbil_lane
  import sbil_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SHW    = 6
) (
  input  logic [DATA_W-1:0]      v00,
  input  logic [DATA_W-1:0]      v01,
  input  logic [DATA_W-1:0]      v10,
  input  logic [DATA_W-1:0]      v11,
  input  logic [SHW-1:0]         s0,
  input  logic [SHW-1:0]         s1,
  input  logic [SHW-1:0]         s2,
  input  logic [SHW-1:0]         s3,
  input  logic                   rnd,
  output logic [3:0][DATA_W-1:0] term,
  input  logic [3:0][DATA_W-1:0] term_q,
  input  logic                   sat,
  output logic [DATA_W-1:0]      res,
  output logic                   flag
);

  localparam int SW = sum_w(DATA_W);

  // Arithmetic right shift with optional round-half-up. The rounding add is
  // done one bit wider so v near the positive limit cannot wrap negative.
  function automatic logic [DATA_W-1:0] shift_term(
    input logic signed [DATA_W-1:0] v,
    input logic        [SHW-1:0]    s,
    input logic                     rnd_en
  );
    logic signed [DATA_W:0] ext;
    logic signed [DATA_W:0] half;
    ext  = {v[DATA_W-1], v};
    half = (DATA_W+1)'(1) << (s - SHW'(1));
    if (s == '0) begin
      return v;
    end else if (int'(s) >= DATA_W) begin
      // Everything shifted out: rounding yields 0, plain shift leaves sign fill.
      return rnd_en ? '0 : {DATA_W{v[DATA_W-1]}};
    end else if (rnd_en) begin
      return DATA_W'((ext + half) >>> s);
    end else begin
      return v >>> s;
    end
  endfunction

  logic signed [SW-1:0]       sum;
  logic        [SW-DATA_W:0]  top_bits;
  logic                       ovf;

  // Front half: four corner terms, registered by the parent as stage 1.
  always_comb begin
    term[0] = shift_term(v00, s0, rnd);
    term[1] = shift_term(v01, s1, rnd);
    term[2] = shift_term(v10, s2, rnd);
    term[3] = shift_term(v11, s3, rnd);
  end

  // Back half: full-precision sum, then clamp or wrap down to DATA_W bits.
  always_comb begin
    sum = SW'(signed'(term_q[0])) + SW'(signed'(term_q[1]))
        + SW'(signed'(term_q[2])) + SW'(signed'(term_q[3]));
    // The sum fits DATA_W bits only when all bits from the DATA_W-1 sign
    // position upward agree.
    top_bits = sum[SW-1:DATA_W-1];
    ovf      = !((&top_bits) || !(|top_bits));
    res      = sum[DATA_W-1:0];
    flag     = 1'b0;
    if (sat && ovf) begin
      flag = 1'b1;
      res  = sum[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/sbilinear_pipe.sv
// NCH-channel four-corner shift-weighted sum with round/saturate modes.
// Latency: 2 cycles from input accept to out_valid when not stalled.
// Backpressure: valid/ready skid-free pipeline; in_ready drops only when both stages are full and out_ready is low.
module sbilinear_pipe
  import sbil_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SHW    = 6,
  parameter int NCH    = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NCH*DATA_W-1:0]   v00,
  input  logic [NCH*DATA_W-1:0]   v01,
  input  logic [NCH*DATA_W-1:0]   v10,
  input  logic [NCH*DATA_W-1:0]   v11,
  input  logic [SHW-1:0]          s0,
  input  logic [SHW-1:0]          s1,
  input  logic [SHW-1:0]          s2,
  input  logic [SHW-1:0]          s3,
  input  logic [1:0]              mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCH*DATA_W-1:0]   out,
  output logic [NCH-1:0]          sat_flag,
  input  logic                    clr_stats,
  output logic [CNT_W-1:0]        sat_cnt
);

  logic                           s1_valid;
  logic                           s2_valid;
  logic                           s2_load;
  logic                           s1_adv;
  logic                           s1_sat;
  logic [NCH-1:0][3:0][DATA_W-1:0] term_d;
  logic [NCH-1:0][3:0][DATA_W-1:0] s1_term;
  logic [NCH*DATA_W-1:0]          res_d;
  logic [NCH-1:0]                 flag_d;
  logic                           sat_hit;

  // Stage 2 drains or is empty -> it can take stage 1; stage 1 then frees up.
  assign s2_load   = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_load;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign sat_hit   = s2_valid && out_ready && (|sat_flag);

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    sbil_lane #(
      .DATA_W (DATA_W),
      .SHW    (SHW)
    ) u_lane (
      .v00    (v00[c*DATA_W +: DATA_W]),
      .v01    (v01[c*DATA_W +: DATA_W]),
      .v10    (v10[c*DATA_W +: DATA_W]),
      .v11    (v11[c*DATA_W +: DATA_W]),
      .s0     (s0),
      .s1     (s1),
      .s2     (s2),
      .s3     (s3),
      .rnd    (mode[MODE_RND]),
      .term   (term_d[c]),
      .term_q (s1_term[c]),
      .sat    (s1_sat),
      .res    (res_d[c*DATA_W +: DATA_W]),
      .flag   (flag_d[c])
    );
  end

  // Stage 1: capture corner terms; only the saturate bit is still needed downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sat   <= 1'b0;
      s1_term  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sat  <= mode[MODE_SAT];
        s1_term <= term_d;
      end
    end
  end

  // Stage 2: narrowed result and flags; held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out      <= '0;
      sat_flag <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out      <= res_d;
        sat_flag <= flag_d;
      end
    end
  end

  // Saturation event counter: clear has priority, count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (clr_stats) begin
      sat_cnt <= '0;
    end else if (sat_hit && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sbilinear_pipe.sv
// Directed bench for sbilinear_pipe: arithmetic modes, stalls, reset, counter.
// Latency: expects results two edges after accept.
// Backpressure: exercises out_ready patterns and checks in_ready against an occupancy model.
module tb_sbilinear_pipe;

  localparam int DW  = 16;
  localparam int SHW = 6;
  localparam int NCH = 4;
  localparam int CW  = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [NCH*DW-1:0]   v00, v01, v10, v11;
  logic [SHW-1:0]      s0, s1, s2, s3;
  logic [1:0]          mode;
  logic                out_valid;
  logic                out_ready;
  logic [NCH*DW-1:0]   out;
  logic [NCH-1:0]      sat_flag;
  logic                clr_stats;
  logic [CW-1:0]       sat_cnt;

  int checks   = 0;
  int failures = 0;

  sbilinear_pipe #(
    .DATA_W (DW),
    .SHW    (SHW),
    .NCH    (NCH),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .v00       (v00),
    .v01       (v01),
    .v10       (v10),
    .v11       (v11),
    .s0        (s0),
    .s1        (s1),
    .s2        (s2),
    .s3        (s3),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .sat_flag  (sat_flag),
    .clr_stats (clr_stats),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [NCH*DW-1:0] pk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic set_beat(input logic [NCH*DW-1:0] a, input logic [NCH*DW-1:0] b,
                          input logic [NCH*DW-1:0] c, input logic [NCH*DW-1:0] d,
                          input logic [SHW-1:0] w0, input logic [SHW-1:0] w1,
                          input logic [SHW-1:0] w2, input logic [SHW-1:0] w3,
                          input logic [1:0] m);
    in_valid = 1'b1;
    v00 = a; v01 = b; v10 = c; v11 = d;
    s0 = w0; s1 = w1; s2 = w2; s3 = w3;
    mode = m;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_stats = 1'b0;
    v00 = '0; v01 = '0; v10 = '0; v11 = '0;
    s0 = '0; s1 = '0; s2 = '0; s3 = '0; mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out !== '0) begin failures++; $display("FAIL reset_out got=%h exp=0", out); end
    checks++; if (sat_flag !== '0) begin failures++; $display("FAIL reset_sat_flag got=%b exp=0", sat_flag); end
    checks++; if (sat_cnt !== '0) begin failures++; $display("FAIL reset_sat_cnt got=%0d exp=0", sat_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [NCH*DW-1:0] exp;
    exp = pk(500, -4, 12, 0);
    set_beat(pk(100, -1, 7, 0), pk(200, -1, 7, 0), pk(300, -1, 7, 0), pk(400, -1, 7, 0),
             6'd1, 6'd1, 6'd1, 6'd1, 2'b00);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_first_accept got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_latency_early got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b exp=1", out_valid); end
    checks++; if (out !== exp) begin failures++; $display("FAIL basic_out got=%h exp=%h", out, exp); end
    checks++; if (sat_flag !== 4'b0000) begin failures++; $display("FAIL basic_flag got=%b exp=0000", sat_flag); end
    @(posedge clk); #1;
  endtask

  task automatic test_round();
    logic [NCH*DW-1:0] exp_r;
    logic [NCH*DW-1:0] exp_t;
    exp_r = pk(2, -1, 8192, -8192);
    exp_t = pk(1, -2, 8190, -8192);
    for (int m = 0; m < 2; m++) begin
      set_beat(pk(6, -6, 32767, -32768), pk(0, 0, -5, 0), '0, '0,
               6'd2, 6'd63, 6'd63, 6'd63, (m == 0) ? 2'b01 : 2'b00);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL round_valid m=%0d got=%b exp=1", m, out_valid); end
      checks++;
      if (out !== ((m == 0) ? exp_r : exp_t)) begin
        failures++; $display("FAIL round_out m=%0d got=%h exp=%h", m, out, (m == 0) ? exp_r : exp_t);
      end
      checks++; if (sat_flag !== 4'b0000) begin failures++; $display("FAIL round_flag m=%0d got=%b exp=0000", m, sat_flag); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturate();
    logic [NCH*DW-1:0] a, b, c, d;
    a = pk(16000, -16000, 1, 8192);
    b = pk(16000, -16000, 2, 8192);
    c = pk(16000, -16000, 3, 8192);
    d = pk(16000, -16000, 4, 8191);
    set_beat(a, b, c, d, 6'd0, 6'd0, 6'd0, 6'd0, 2'b10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out !== pk(32767, -32768, 10, 32767)) begin failures++; $display("FAIL sat_out got=%h exp=%h", out, pk(32767, -32768, 10, 32767)); end
    checks++; if (sat_flag !== 4'b0011) begin failures++; $display("FAIL sat_flag got=%b exp=0011", sat_flag); end
    checks++; if (sat_cnt !== 4'd0) begin failures++; $display("FAIL sat_cnt_before got=%0d exp=0", sat_cnt); end
    @(posedge clk); #1;
    checks++; if (sat_cnt !== 4'd1) begin failures++; $display("FAIL sat_cnt_after got=%0d exp=1", sat_cnt); end
    set_beat(a, b, c, d, 6'd0, 6'd0, 6'd0, 6'd0, 2'b00);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out !== pk(-1536, 1536, 10, 32767)) begin failures++; $display("FAIL wrap_out got=%h exp=%h", out, pk(-1536, 1536, 10, 32767)); end
    checks++; if (sat_flag !== 4'b0000) begin failures++; $display("FAIL wrap_flag got=%b exp=0000", sat_flag); end
    @(posedge clk); #1;
    checks++; if (sat_cnt !== 4'd1) begin failures++; $display("FAIL wrap_cnt got=%0d exp=1", sat_cnt); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got  = 0;
    int occ  = 0;
    int cyc  = 0;
    logic hold_vld = 1'b0;
    logic [NCH*DW-1:0] hold_dat = '0;
    logic exp_rdy, acc, dlv;
    while (got < 10 && cyc < 200) begin
      @(posedge clk); #1;
      out_ready = (cyc % 3 == 0);
      if (sent < 10) set_beat(pk(sent + 1, 0, 0, 0), '0, '0, '0, 6'd0, 6'd0, 6'd0, 6'd0, 2'b00);
      else in_valid = 1'b0;
      @(negedge clk);
      exp_rdy = !(occ == 2 && !out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
      if (hold_vld) begin
        checks++;
        if (out_valid !== 1'b1 || out !== hold_dat) begin
          failures++; $display("FAIL b2b_stall_hold cyc=%0d got=%b/%h exp=1/%h", cyc, out_valid, out, hold_dat);
        end
      end
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (dlv) begin
        checks++;
        if (out !== pk(got + 1, 0, 0, 0)) begin failures++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", got, out, pk(got + 1, 0, 0, 0)); end
        got++;
      end
      hold_vld = out_valid && !out_ready;
      hold_dat = out;
      if (acc) sent++;
      occ = occ + int'(acc) - int'(dlv);
      cyc++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != 10 || sent != 10) begin failures++; $display("FAIL b2b_count got=%0d/%0d exp=10/10", got, sent); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    set_beat(pk(11, 0, 0, 0), '0, '0, '0, 6'd0, 6'd0, 6'd0, 6'd0, 2'b00);
    @(posedge clk); #1;
    set_beat(pk(22, 0, 0, 0), '0, '0, '0, 6'd0, 6'd0, 6'd0, 6'd0, 2'b00);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_inflight got=%b exp=1", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    set_beat(pk(33, 0, 0, 0), '0, '0, '0, 6'd0, 6'd0, 6'd0, 6'd0, 2'b00);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_after_early got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out !== pk(33, 0, 0, 0)) begin failures++; $display("FAIL mid_after_out got=%b/%h exp=1/%h", out_valid, out, pk(33, 0, 0, 0)); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_no_stale got=%b exp=0", out_valid); end
  endtask

  task automatic test_cnt_sat();
    out_ready = 1'b1;
    set_beat(pk(16000, 0, 0, 0), pk(16000, 0, 0, 0), pk(16000, 0, 0, 0), pk(16000, 0, 0, 0),
             6'd0, 6'd0, 6'd0, 6'd0, 2'b10);
    repeat (20) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sat_cnt !== 4'd15) begin failures++; $display("FAIL cnt_stick got=%0d exp=15", sat_cnt); end
    set_beat(pk(16000, 0, 0, 0), pk(16000, 0, 0, 0), pk(16000, 0, 0, 0), pk(16000, 0, 0, 0),
             6'd0, 6'd0, 6'd0, 6'd0, 2'b10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || sat_flag !== 4'b0001) begin failures++; $display("FAIL cnt_beat got=%b/%b exp=1/0001", out_valid, sat_flag); end
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    checks++; if (sat_cnt !== 4'd0) begin failures++; $display("FAIL cnt_clear_wins got=%0d exp=0", sat_cnt); end
    set_beat(pk(16000, 0, 0, 0), pk(16000, 0, 0, 0), pk(16000, 0, 0, 0), pk(16000, 0, 0, 0),
             6'd0, 6'd0, 6'd0, 6'd0, 2'b10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (sat_cnt !== 4'd1) begin failures++; $display("FAIL cnt_restart got=%0d exp=1", sat_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_saturate();
    test_back_to_back();
    test_reset_midstream();
    test_cnt_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
